decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
// Registered instruction-decode pipeline stage, successor to the combinational decoder. Decodes
// 16-bit instructions into one-hot class flags plus a WIDTH-bit constant, behind a valid/ready
// handshake. Adds prefix (PFX) instructions that build constants wider than 16 bits, an OUT_HI
// class, a flush input and a saturating count of unknown instructions.
// PARAMETERS
// WIDTH  16  datapath/constant width; multiple of 8, >=16
// CNT_W  8   width of unknown-instruction counter
// PORTS
// clk              in   1      clock, rising edge
// rst_n            in   1      async active-low reset
// flush            in   1      sync: drop output beat and prefix state
// in_valid         in   1      in_inst valid
// in_ready         out  1      stage can accept in_inst
// in_inst          in   16     instruction word
// out_valid        out  1      decoded beat valid
// out_ready        in   1      consumer accepts beat
// out_nop/out_load/out_add/out_out_lo/out_out_hi/out_unknown  out 1 each  one-hot class
// out_source_const out  1      operand is out_constval
// out_constval     out  WIDTH  constant (0 when !out_source_const)
// out_pfx_dropped  out  1      pending prefix discarded by this beat
// pfx_pending      out  1      prefix accumulator non-empty
// unknown_count    out  CNT_W  saturating count of unknown beats delivered
// BEHAVIOUR
// - Encoding: 0x00xx NOP; 0x01ii PFX; 0x08xx OUT_LO; 0x09xx OUT_HI; (inst&FC00)==8000 LOAD,
//   ==8400 ADD; LOAD/ADD: inst[9]=0 const source, inst[8]=b byte position, ii=inst[7:0].
//   All other words UNKNOWN.
// - Reset: every output 0 except in_ready=1; prefix accumulator, count and counter 0.
// - in_ready = !out_valid | out_ready (combinational, all opcodes). Accept = in_valid & in_ready.
// - Latency 1: accepted non-PFX word appears at out_valid next cycle. Beat holds stable until
//   out_ready. Accept and drain in same cycle allowed (full throughput).
// - PFX is consumed internally; it produces no output beat, and out_valid falls if the current
//   beat drains in that cycle. MAXP = WIDTH/8-1.
// - PFX accepted with pfx_cnt<MAXP: acc <= (acc<<8)|ii, truncated to WIDTH-8 bits; cnt++.
// - PFX accepted with pfx_cnt==MAXP: emits UNKNOWN beat; acc/cnt unchanged.
// - Const LOAD/ADD: constval = ({acc,ii} << 8*b) truncated to WIDTH; no prefix => {0,ii}<<8*b.
//   Then acc, cnt <= 0.
// - Any other non-PFX word accepted with cnt!=0 (NOP, OUT, register source, unknown):
//   out_pfx_dropped=1 on that beat; acc, cnt <= 0.
// - unknown_count increments when an UNKNOWN beat completes (out_valid & out_ready);
//   saturates at 2^CNT_W-1.
// - flush: next cycle out_valid=0 and acc/cnt=0. Word presented with flush is not accepted:
//   in_ready is forced 0 while flush=1. unknown_count is unaffected.
// - Async reset mid-beat: immediate return to reset values; no partial prefix survives.
// TESTING
// WIDTH=16: 0x8012 -> load, const, constval 0x0012. 0x8134 -> constval 0x3400.
//   0x0800 -> out_lo, constval 0.
// WIDTH=32: PFX 0x01AB, PFX 0x01CD, LOAD 0x80EF -> one beat, constval 0x00ABCDEF, pfx_pending 0.
// WIDTH=16: PFX 0x0112, PFX 0x0134 -> second yields unknown beat, count=1.
//   Then 0x8056 -> constval 0x1256.
// PFX 0x0177 then ADD 0x8605 (register) -> add, source_const 0, pfx_dropped 1, constval 0.
// out_ready=0 for 5 cycles with stream queued -> beat stable, in_ready=0, no loss or duplication.
//   Random stall/flush stress vs reference model.
// 300 unknown beats (0x7F00), CNT_W=8 -> unknown_count saturates at 255.
//   Reset mid-prefix -> pfx_pending=0.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake, prefix-built wide constants,
// flush, and a saturating count of delivered unknown instructions.
module decode_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_nop,
    output logic             out_load,
    output logic             out_add,
    output logic             out_out_lo,
    output logic             out_out_hi,
    output logic             out_unknown,
    output logic             out_source_const,
    output logic [WIDTH-1:0] out_constval,
    output logic             out_pfx_dropped,
    output logic             pfx_pending,
    output logic [CNT_W-1:0] unknown_count
);

    localparam int MAXP = WIDTH / 8 - 1;
    localparam int PCW  = (MAXP > 1) ? $clog2(MAXP + 1) : 1;
    localparam int AW   = WIDTH - 8;
    localparam logic [PCW-1:0] MAXP_C = PCW'(MAXP);

    typedef struct packed {
        logic             nop;
        logic             load;
        logic             add;
        logic             out_lo;
        logic             out_hi;
        logic             unknown;
        logic             source_const;
        logic             pfx_dropped;
        logic [WIDTH-1:0] constval;
    } beat_t;

    beat_t            beat_q, beat_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0] ucnt_q, ucnt_d;

    logic [7:0]       op;
    logic [7:0]       ii;
    logic             is_pfx, is_load, is_add, is_const;
    logic             accept;
    logic [WIDTH-1:0] cat;
    logic [WIDTH-1:0] const_val;

    assign op       = in_inst[15:8];
    assign ii       = in_inst[7:0];
    assign is_pfx   = (op == 8'h01);
    assign is_load  = (in_inst[15:10] == 6'b100000);
    assign is_add   = (in_inst[15:10] == 6'b100001);
    assign is_const = (is_load | is_add) & ~in_inst[9];

    // {acc,ii} doubles as the next accumulator (low AW bits) and the unshifted constant.
    assign cat       = {acc_q, ii};
    assign const_val = in_inst[8] ? (cat << 8) : cat;

    assign in_ready = ~flush & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        beat_d  = beat_q;
        valid_d = valid_q;
        acc_d   = acc_q;
        pcnt_d  = pcnt_q;
        ucnt_d  = ucnt_q;

        if (valid_q && out_ready && beat_q.unknown && (ucnt_q != '1))
            ucnt_d = ucnt_q + 1'b1;

        if (flush) begin
            valid_d = 1'b0;
            beat_d  = '0;
            acc_d   = '0;
            pcnt_d  = '0;
        end else begin
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
                beat_d  = '0;
            end
            if (accept) begin
                if (is_pfx && (pcnt_q != MAXP_C)) begin
                    acc_d  = cat[AW-1:0];
                    pcnt_d = pcnt_q + 1'b1;
                end else begin
                    valid_d = 1'b1;
                    beat_d  = '0;
                    if (is_pfx) begin
                        // Prefix overflow: the accumulator is kept, only an unknown beat is emitted.
                        beat_d.unknown = 1'b1;
                    end else begin
                        acc_d  = '0;
                        pcnt_d = '0;
                        if (is_const) begin
                            beat_d.load         = is_load;
                            beat_d.add          = is_add;
                            beat_d.source_const = 1'b1;
                            beat_d.constval     = const_val;
                        end else begin
                            beat_d.pfx_dropped = (pcnt_q != '0);
                            beat_d.nop         = (op == 8'h00);
                            beat_d.out_lo      = (op == 8'h08);
                            beat_d.out_hi      = (op == 8'h09);
                            beat_d.load        = is_load;
                            beat_d.add         = is_add;
                            beat_d.unknown     = ~((op == 8'h00) | (op == 8'h08) | (op == 8'h09)
                                                   | is_load | is_add);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            pcnt_q  <= '0;
            ucnt_q  <= '0;
        end else begin
            beat_q  <= beat_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            pcnt_q  <= pcnt_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_nop          = beat_q.nop;
    assign out_load         = beat_q.load;
    assign out_add          = beat_q.add;
    assign out_out_lo       = beat_q.out_lo;
    assign out_out_hi       = beat_q.out_hi;
    assign out_unknown      = beat_q.unknown;
    assign out_source_const = beat_q.source_const;
    assign out_constval     = beat_q.constval;
    assign out_pfx_dropped  = beat_q.pfx_dropped;
    assign pfx_pending      = (pcnt_q != '0);
    assign unknown_count    = ucnt_q;

endmodule
